// File: rtl/exp6_pkg.sv
// Shared definitions for the exp6 game: FSM state encoding, default sizes,
// and the one-hot test used by the play detector and the datapath.
package exp6_pkg;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        FILTRANDO     = 2'd1,
        VALIDO        = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    localparam int N_BOTOES_PADRAO        = 4;
    localparam int DEBOUNCE_CICLOS_PADRAO = 50000;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/exp6_sincronizador.sv
// Two-stage synchroniser for asynchronous button levels,
// synchronous active-low reset.
module exp6_sincronizador #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] entrada,
    output logic [LARGURA-1:0] saida
);

    logic [LARGURA-1:0] meta;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta  <= '0;
            saida <= '0;
        end else begin
            meta  <= entrada;
            saida <= meta;
        end
    end

endmodule

// File: rtl/exp6_detector_jogada.sv
// Debounces the player buttons and encodes one accepted press as a one-hot play.
// Optional DETECTOR_MULTIPLOS_EN adds the sticky db_multiplos debug flag.
module exp6_detector_jogada
    import exp6_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_PADRAO,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
    parameter int W_CONT          = $clog2(DEBOUNCE_CICLOS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                limpa,
    output logic                jogada_feita,
    output logic [N_BOTOES-1:0] jogada,
    output logic [1:0]          db_estado
`ifdef DETECTOR_MULTIPLOS_EN
    ,
    output logic                db_multiplos
`endif
);

    localparam logic [W_CONT-1:0] ULTIMO = W_CONT'(DEBOUNCE_CICLOS - 1);

    logic [N_BOTOES-1:0] sinc;
    logic [N_BOTOES-1:0] candidato, candidatoProx;
    logic [N_BOTOES-1:0] jogadaProx;
    logic [W_CONT-1:0]   contador, contadorProx;
    estado_t             estado, estadoProx;
    logic                umBotao;

    exp6_sincronizador #(
        .LARGURA(N_BOTOES)
    ) uSinc (
        .clock  (clock),
        .reset  (reset),
        .entrada(botoes),
        .saida  (sinc)
    );

    assign umBotao = is_onehot(32'(sinc));

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado    <= OCIOSO;
            contador  <= '0;
            candidato <= '0;
            jogada    <= '0;
        end else begin
            estado    <= estadoProx;
            contador  <= contadorProx;
            candidato <= candidatoProx;
            jogada    <= jogadaProx;
        end
    end

    // A load on the way into VALIDO overrides a simultaneous limpa.
    always_comb begin
        estadoProx    = estado;
        contadorProx  = contador;
        candidatoProx = candidato;
        jogadaProx    = limpa ? '0 : jogada;
        unique case (estado)
            OCIOSO: begin
                if (umBotao) begin
                    candidatoProx = sinc;
                    contadorProx  = '0;
                    estadoProx    = FILTRANDO;
                end
            end
            FILTRANDO: begin
                if (sinc != candidato) begin
                    estadoProx = OCIOSO;
                end else if (contador == ULTIMO) begin
                    estadoProx = VALIDO;
                    jogadaProx = candidato;
                end else begin
                    contadorProx = contador + W_CONT'(1);
                end
            end
            VALIDO: begin
                contadorProx = '0;
                estadoProx   = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                if (sinc != '0) begin
                    contadorProx = '0;
                end else if (contador == ULTIMO) begin
                    estadoProx = OCIOSO;
                end else begin
                    contadorProx = contador + W_CONT'(1);
                end
            end
            default: estadoProx = OCIOSO;
        endcase
    end

    assign jogada_feita = (estado == VALIDO);
    assign db_estado    = estado;

`ifdef DETECTOR_MULTIPLOS_EN
    logic multiplos, multiplosProx;

    always_comb begin
        multiplosProx = limpa ? 1'b0 : multiplos;
        if ((estado == OCIOSO || estado == FILTRANDO) &&
            sinc != '0 && !umBotao)
            multiplosProx = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) multiplos <= 1'b0;
        else        multiplos <= multiplosProx;
    end

    assign db_multiplos = multiplos;
`endif

endmodule
